// File: rtl/auth_pkg.sv
// Shared types and defaults for the authentication session controller.
// AUTH_LOCKOUT_EN adds the LOCKED state to the state encoding.
package auth_pkg;

  localparam int unsigned ID_W             = 3;
  localparam int unsigned TIMER_W          = 16;
  localparam int unsigned FAIL_W           = 2;
  localparam int unsigned DEF_MAX_TRIES    = 3;
  localparam int unsigned DEF_LOCK_CYCLES  = 1000;
  localparam int unsigned DEF_IDLE_TIMEOUT = 5000;

`ifdef AUTH_LOCKOUT_EN
  typedef enum logic [1:0] {
    ST_ID_WAIT   = 2'd0,
    ST_PSWD_WAIT = 2'd1,
    ST_SESSION   = 2'd2,
    ST_LOCKED    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_ID_WAIT   = 2'd0,
    ST_PSWD_WAIT = 2'd1,
    ST_SESSION   = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/auth_session_ctrl_if.sv
// Handshake bundle between the ID/password stages, game control and the
// session controller. The master drives the request strobes, the slave
// (controller) drives the session status.
interface auth_session_ctrl_if;
  import auth_pkg::*;

  logic              matchedID;
  logic [ID_W-1:0]   ID_internal_from_ID;
  logic              pswd_ok;
  logic              pswd_fail;
  logic              UserLoad;
  logic              logout_from_gamectrl;

  logic              id_enable;
  logic              pswd_enable;
  logic [ID_W-1:0]   PlayerID_internal;
  logic              LoggedIn;
  logic              logout;
  logic              locked;
  logic [FAIL_W-1:0] fail_count;

  modport master (
    output matchedID, ID_internal_from_ID, pswd_ok, pswd_fail, UserLoad,
           logout_from_gamectrl,
    input  id_enable, pswd_enable, PlayerID_internal, LoggedIn, logout,
           locked, fail_count
  );

  modport slave (
    input  matchedID, ID_internal_from_ID, pswd_ok, pswd_fail, UserLoad,
           logout_from_gamectrl,
    output id_enable, pswd_enable, PlayerID_internal, LoggedIn, logout,
           locked, fail_count
  );

endinterface

// File: rtl/auth_timer.sv
// Loadable down-counter shared by idle and lockout timing. zero_o flags the
// edge on which the count reaches zero, so a load of N expires exactly N
// cycles later; a load in the same cycle suppresses the flag.
module auth_timer
  import auth_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero_o = !load_i && (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/auth_session_ctrl.sv
// Login session controller: ID entry, password check with failure counting,
// idle timeout and optional lockout (enabled by defining AUTH_LOCKOUT_EN).
module auth_session_ctrl
  import auth_pkg::*;
#(
  parameter int unsigned MAX_TRIES    = DEF_MAX_TRIES,
  parameter int unsigned LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  auth_session_ctrl_if.slave  bus
);

  localparam logic [TIMER_W-1:0] IDLE_VAL = TIMER_W'(IDLE_TIMEOUT);
`ifdef AUTH_LOCKOUT_EN
  localparam logic [TIMER_W-1:0] LOCK_VAL = TIMER_W'(LOCK_CYCLES);
`endif

  state_e            state_q;
  logic [ID_W-1:0]   player_id_q;
  logic              logged_in_q;
  logic              logout_q;
  logic [FAIL_W-1:0] fail_count_q;
  logic              id_enable_q;
  logic              pswd_enable_q;
`ifdef AUTH_LOCKOUT_EN
  logic              locked_q;
`endif

  logic               fail_c;
  logic               ok_c;
  logic [FAIL_W-1:0]  fail_next_c;
  logic               fail_max_c;
  logic               tmr_load_c;
  logic [TIMER_W-1:0] tmr_val_c;
  logic               tmr_zero_c;

  // A simultaneous ok/fail counts as a failure.
  assign fail_c      = bus.pswd_fail;
  assign ok_c        = bus.pswd_ok && !bus.pswd_fail;
  assign fail_next_c = fail_count_q + FAIL_W'(1);
  assign fail_max_c  = (fail_next_c == FAIL_W'(MAX_TRIES));

  // Timer reloads on state entry and on user activity in the active states.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = IDLE_VAL;
    case (state_q)
      ST_ID_WAIT: begin
        if (bus.matchedID) tmr_load_c = 1'b1;
      end
      ST_PSWD_WAIT: begin
        if (fail_c && fail_max_c) begin
`ifdef AUTH_LOCKOUT_EN
          tmr_load_c = 1'b1;
          tmr_val_c  = LOCK_VAL;
`endif
        end else if (ok_c || bus.UserLoad) begin
          tmr_load_c = 1'b1;
        end
      end
      ST_SESSION: begin
        if (bus.UserLoad) tmr_load_c = 1'b1;
      end
      default: ;
    endcase
  end

  auth_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .zero_o     (tmr_zero_c)
  );

  // Session FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ID_WAIT;
      player_id_q   <= '0;
      logged_in_q   <= 1'b0;
      logout_q      <= 1'b0;
      fail_count_q  <= '0;
      id_enable_q   <= 1'b1;
      pswd_enable_q <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      locked_q      <= 1'b0;
`endif
    end else begin
      logout_q <= 1'b0;
      case (state_q)
        ST_ID_WAIT: begin
          if (bus.matchedID) begin
            state_q       <= ST_PSWD_WAIT;
            player_id_q   <= bus.ID_internal_from_ID;
            id_enable_q   <= 1'b0;
            pswd_enable_q <= 1'b1;
          end
        end
        ST_PSWD_WAIT: begin
          if (fail_c && fail_max_c) begin
            pswd_enable_q <= 1'b0;
            player_id_q   <= '0;
`ifdef AUTH_LOCKOUT_EN
            state_q       <= ST_LOCKED;
            fail_count_q  <= fail_next_c;
            locked_q      <= 1'b1;
`else
            state_q       <= ST_ID_WAIT;
            fail_count_q  <= '0;
            logout_q      <= 1'b1;
            id_enable_q   <= 1'b1;
`endif
          end else if (ok_c) begin
            state_q       <= ST_SESSION;
            fail_count_q  <= '0;
            logged_in_q   <= 1'b1;
            pswd_enable_q <= 1'b0;
          end else begin
            if (fail_c) fail_count_q <= fail_next_c;
            // Abandoned password entry: drop the attempt but keep the count.
            if (tmr_zero_c) begin
              state_q       <= ST_ID_WAIT;
              player_id_q   <= '0;
              logout_q      <= 1'b1;
              id_enable_q   <= 1'b1;
              pswd_enable_q <= 1'b0;
            end
          end
        end
        ST_SESSION: begin
          if (bus.logout_from_gamectrl || tmr_zero_c) begin
            state_q     <= ST_ID_WAIT;
            player_id_q <= '0;
            logged_in_q <= 1'b0;
            logout_q    <= 1'b1;
            id_enable_q <= 1'b1;
          end
        end
`ifdef AUTH_LOCKOUT_EN
        ST_LOCKED: begin
          if (tmr_zero_c) begin
            state_q      <= ST_ID_WAIT;
            fail_count_q <= '0;
            locked_q     <= 1'b0;
            id_enable_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q       <= ST_ID_WAIT;
          player_id_q   <= '0;
          logged_in_q   <= 1'b0;
          id_enable_q   <= 1'b1;
          pswd_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.id_enable         = id_enable_q;
  assign bus.pswd_enable       = pswd_enable_q;
  assign bus.PlayerID_internal = player_id_q;
  assign bus.LoggedIn          = logged_in_q;
  assign bus.logout            = logout_q;
  assign bus.fail_count        = fail_count_q;
`ifdef AUTH_LOCKOUT_EN
  assign bus.locked            = locked_q;
`else
  assign bus.locked            = 1'b0;
`endif

endmodule

// File: doc/auth_session_ctrl.md
AUTH_SESSION_CTRL -- requirements
Module: auth_session_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3: consecutive password failures that trigger lockout; legal range 1..3.
REQ-002 Parameter LOCK_CYCLES, default 1000: lockout duration in clk cycles; legal range 1..65535.
REQ-003 Parameter IDLE_TIMEOUT, default 5000: inactivity limit in clk cycles; legal range 2..65535.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 matchedID  in  1  one-cycle pulse: ID stage found a valid user.
REQ-007 ID_internal_from_ID  in  3  internal player ID; valid with matchedID.
REQ-008 pswd_ok  in  1  one-cycle pulse: password matched.
REQ-009 pswd_fail  in  1  one-cycle pulse: password mismatched.
REQ-010 UserLoad  in  1  user activity strobe; restarts the idle timer.
REQ-011 logout_from_gamectrl  in  1  one-cycle pulse: game requests logout.
REQ-012 id_enable  out  1  high while the ID stage may accept entry.
REQ-013 pswd_enable  out  1  high while the password stage may accept entry.
REQ-014 PlayerID_internal  out  3  latched session player ID.
REQ-015 LoggedIn  out  1  high while a session is active.
REQ-016 logout  out  1  one-cycle pulse on every session or attempt termination.
REQ-017 locked  out  1  high during lockout.
REQ-018 fail_count  out  2  current consecutive-failure count.

Function
REQ-019 FSM states: ID_WAIT, PSWD_WAIT, SESSION, LOCKED; all outputs registered.
REQ-020 ID_WAIT: id_enable=1; matchedID latches ID_internal_from_ID into PlayerID_internal and enters PSWD_WAIT next cycle.
REQ-021 PSWD_WAIT: pswd_enable=1; pswd_ok enters SESSION, clears fail_count and sets LoggedIn on the next edge.
REQ-022 PSWD_WAIT: pswd_fail increments fail_count; if the new count equals MAX_TRIES, enter LOCKED; otherwise remain.
REQ-023 pswd_ok and pswd_fail in the same cycle: treated as pswd_fail.
REQ-024 SESSION: logout_from_gamectrl causes a logout pulse, clears LoggedIn and PlayerID_internal, and enters ID_WAIT.
REQ-025 Idle timer: 16-bit counter loaded with IDLE_TIMEOUT on entry to PSWD_WAIT or SESSION and on every UserLoad; decrements each cycle otherwise.
REQ-026 Timer reaching 0 in PSWD_WAIT or SESSION: logout pulse, clear session outputs, enter ID_WAIT; fail_count is kept.
REQ-027 UserLoad coinciding with timer expiry: the reload wins and no timeout occurs.
REQ-028 logout_from_gamectrl coinciding with timer expiry: exactly one logout pulse.
REQ-029 LOCKED: locked=1; id_enable=0 and pswd_enable=0; all inputs ignored; the timer loads LOCK_CYCLES on entry.
REQ-030 LOCKED exit: at timer 0, clear fail_count and locked, and enter ID_WAIT.
REQ-031 matchedID, pswd_ok and pswd_fail are ignored in any state where they are not listed.

Reset
REQ-032 rst: state=ID_WAIT, PlayerID_internal=0, LoggedIn=0, logout=0, locked=0, fail_count=0, timer=0, id_enable=1, pswd_enable=0.
REQ-033 rst overrides all inputs in the same cycle, including mid-session and mid-lockout; no logout pulse is generated.

Configuration
REQ-034 Macro AUTH_LOCKOUT_EN defined: LOCKED state and lockout behaviour exactly as specified in REQ-022, REQ-029 and REQ-030.
REQ-035 Macro undefined: LOCKED state is absent and locked is tied to 0; reaching MAX_TRIES causes a logout pulse, clears fail_count and enters ID_WAIT.

Structure
REQ-036 Shared package auth_pkg: state encoding, ID width (3), timer width (16), default MAX_TRIES, LOCK_CYCLES and IDLE_TIMEOUT.
REQ-037 One sub-module, auth_timer: loadable 16-bit down-counter with load, load value and zero-flag outputs; used for both idle and lockout timing.

Verification
REQ-038 Login: matchedID with ID=5, then pswd_ok 3 cycles later -> LoggedIn=1 and PlayerID_internal=5 one cycle after pswd_ok; fail_count=0.
REQ-039 Lockout (macro on, MAX_TRIES=3, LOCK_CYCLES=20): three pswd_fail pulses -> locked=1 for 20 cycles, matchedID ignored during lockout, then ID_WAIT with fail_count=0.
REQ-040 Idle timeout (IDLE_TIMEOUT=10): session with no UserLoad -> single logout pulse 10 cycles after entry; UserLoad at cycle 9 defers expiry to 10 cycles after the UserLoad.
REQ-041 Simultaneous events: pswd_ok together with pswd_fail -> fail_count increments and no login; logout_from_gamectrl at timer expiry -> exactly one logout pulse.
REQ-042 Reset mid-session and mid-lockout -> all outputs match REQ-032 next cycle and no logout pulse.
REQ-043 Macro off: three failures -> one logout pulse, fail_count=0, state ID_WAIT, locked stays 0.
